// File: rtl/matrix_mem.sv
// Playfield storage for the game matrix: combinational read port, synchronous
// write port, sequenced whole-field clear and a flow-controlled row-scan stream.
module matrix_mem #(
  parameter int unsigned width_p  = 16,
  parameter int unsigned height_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [$clog2(height_p)-1:0] mm_read_addr_i,
  output logic [width_p-1:0]          mm_read_data_o,
  input  logic [$clog2(height_p)-1:0] mm_write_addr_i,
  input  logic [width_p-1:0]          mm_write_data_i,
  input  logic                        mm_write_v_i,
  input  logic                        clear_i,
  output logic                        busy_o,
  output logic                        clear_done_o,
  input  logic                        scan_start_i,
  output logic                        scan_v_o,
  input  logic                        scan_ready_i,
  output logic [$clog2(height_p)-1:0] scan_row_o,
  output logic [width_p-1:0]          scan_data_o,
  output logic                        scan_last_o,
  output logic                        top_occupied_o
);

  localparam int unsigned AW       = $clog2(height_p);
  localparam logic [AW:0]   HEIGHT   = (AW+1)'(height_p);
  localparam logic [AW-1:0] LAST_ROW = AW'(height_p - 1);

  typedef enum logic {eIDLE, eCLEAR} clr_state_e;
  typedef enum logic {sIDLE, sRUN}   scan_state_e;

  logic [width_p-1:0] r_array [height_p];

  clr_state_e         r_clr_state;
  logic [AW-1:0]      r_clr_ptr;

  scan_state_e        r_scan_state;
  logic               r_scan_v;
  logic [AW-1:0]      r_scan_row;
  logic [width_p-1:0] r_scan_data;

  logic               w_rd_ok;
  logic               w_wr_ok;
  logic               w_wr_en;
  logic [AW-1:0]      w_scan_next;

  assign w_rd_ok     = ({1'b0, mm_read_addr_i} < HEIGHT);
  assign w_wr_ok     = ({1'b0, mm_write_addr_i} < HEIGHT);
  // A clear request in idle takes priority over a same-cycle write.
  assign w_wr_en     = (r_clr_state == eIDLE) && !clear_i && mm_write_v_i && w_wr_ok;
  assign w_scan_next = r_scan_row + AW'(1);

  assign mm_read_data_o = w_rd_ok ? r_array[mm_read_addr_i] : '0;
  assign top_occupied_o = |r_array[0];
  assign busy_o         = (r_clr_state == eCLEAR);
  assign clear_done_o   = (r_clr_state == eCLEAR) && (r_clr_ptr == LAST_ROW);
  assign scan_v_o       = r_scan_v;
  assign scan_row_o     = r_scan_row;
  assign scan_data_o    = r_scan_data;
  assign scan_last_o    = r_scan_v && (r_scan_row == LAST_ROW);

  // Storage: executor writes in idle, one row zeroed per cycle while clearing.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < height_p; i++) begin
        r_array[i] <= '0;
      end
    end else if (r_clr_state == eCLEAR) begin
      r_array[r_clr_ptr] <= '0;
    end else if (w_wr_en) begin
      r_array[mm_write_addr_i] <= mm_write_data_i;
    end
  end

  // Clear sequencer: walks the pointer from row 0 to the last row.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_clr_state <= eIDLE;
      r_clr_ptr   <= '0;
    end else begin
      case (r_clr_state)
        eIDLE: begin
          if (clear_i) begin
            r_clr_state <= eCLEAR;
            r_clr_ptr   <= '0;
          end
        end
        eCLEAR: begin
          if (r_clr_ptr == LAST_ROW) begin
            r_clr_state <= eIDLE;
            r_clr_ptr   <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + AW'(1);
          end
        end
        default: begin
          r_clr_state <= eIDLE;
          r_clr_ptr   <= '0;
        end
      endcase
    end
  end

  // Row-scan streamer: captures a row snapshot per accepted beat, holds under stall.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_scan_state <= sIDLE;
      r_scan_v     <= 1'b0;
      r_scan_row   <= '0;
      r_scan_data  <= '0;
    end else begin
      case (r_scan_state)
        sIDLE: begin
          if (scan_start_i) begin
            r_scan_state <= sRUN;
            r_scan_v     <= 1'b1;
            r_scan_row   <= '0;
            r_scan_data  <= r_array[0];
          end
        end
        sRUN: begin
          if (r_scan_v && scan_ready_i) begin
            if (r_scan_row == LAST_ROW) begin
              r_scan_state <= sIDLE;
              r_scan_v     <= 1'b0;
            end else begin
              r_scan_row  <= w_scan_next;
              r_scan_data <= r_array[w_scan_next];
            end
          end
        end
        default: begin
          r_scan_state <= sIDLE;
          r_scan_v     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mem.sv
// Randomized scoreboard bench for matrix_mem against a plain array model.
module tb_matrix_mem;

  localparam int W = 16;
  localparam int H = 32;

  logic          clk;
  logic          reset_i;
  logic [4:0]    mm_read_addr_i;
  logic [W-1:0]  mm_read_data_o;
  logic [4:0]    mm_write_addr_i;
  logic [W-1:0]  mm_write_data_i;
  logic          mm_write_v_i;
  logic          clear_i;
  logic          busy_o;
  logic          clear_done_o;
  logic          scan_start_i;
  logic          scan_v_o;
  logic          scan_ready_i;
  logic [4:0]    scan_row_o;
  logic [W-1:0]  scan_data_o;
  logic          scan_last_o;
  logic          top_occupied_o;

  matrix_mem #(.width_p(W), .height_p(H)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .mm_read_addr_i(mm_read_addr_i), .mm_read_data_o(mm_read_data_o),
    .mm_write_addr_i(mm_write_addr_i), .mm_write_data_i(mm_write_data_i),
    .mm_write_v_i(mm_write_v_i), .clear_i(clear_i), .busy_o(busy_o),
    .clear_done_o(clear_done_o), .scan_start_i(scan_start_i), .scan_v_o(scan_v_o),
    .scan_ready_i(scan_ready_i), .scan_row_o(scan_row_o), .scan_data_o(scan_data_o),
    .scan_last_o(scan_last_o), .top_occupied_o(top_occupied_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int row; logic [W-1:0] data; } beat_t;

  // Reference model: field contents, clear cycles remaining, presented scan row.
  logic [W-1:0] model [H];
  int           clr_left;
  int           m_row;
  beat_t        q [$];

  int n_cmp = 0;
  int n_err = 0;
  int n_beats = 0;
  int n_last = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < H; i++) model[i] = '0;
    clr_left = 0;
    m_row    = -1;
    q.delete();
  endtask

  // One clock: advance the model with the inputs held across the edge, then check.
  task automatic step();
    beat_t b;
    @(posedge clk);
    if (!reset_i) begin
      if (m_row < 0) begin
        if (scan_start_i) begin
          m_row = 0; b.row = 0; b.data = model[0]; q.push_back(b);
        end
      end else if (scan_ready_i) begin
        if (m_row == H-1) m_row = -1;
        else begin
          m_row++; b.row = m_row; b.data = model[m_row]; q.push_back(b);
        end
      end
      if (clr_left > 0) begin
        model[H-clr_left] = '0;
        clr_left--;
      end else if (clear_i) begin
        clr_left = H;
      end else if (mm_write_v_i) begin
        model[mm_write_addr_i] = mm_write_data_i;
      end
    end
    #1;
    chk("busy", busy_o, clr_left > 0);
    chk("clear_done", clear_done_o, clr_left == 1);
    chk("scan_v", scan_v_o, m_row >= 0);
    chk("read_data", mm_read_data_o, model[mm_read_addr_i]);
    chk("top_occupied", top_occupied_o, |model[0]);
  endtask

  task automatic idle_inputs();
    mm_write_v_i = 0; clear_i = 0; scan_start_i = 0; scan_ready_i = 0;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    mm_write_v_i = 1; mm_write_addr_i = 5'(a); mm_write_data_i = d;
    step();
    mm_write_v_i = 0;
  endtask

  // Sweep the read port over every row; only used while nothing is in flight.
  task automatic rd_all(input string nm);
    for (int i = 0; i < H; i++) begin
      mm_read_addr_i = 5'(i);
      @(negedge clk);
      chk(nm, mm_read_data_o, model[i]);
    end
  endtask

  // Scan monitor: compares each presented beat with the scoreboard head.
  logic          prev_stall;
  logic [4:0]    prev_row;
  logic [W-1:0]  prev_data;
  always @(negedge clk) begin
    if (reset_i) begin
      prev_stall = 1'b0;
    end else begin
      if (scan_v_o) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scan_unexpected: got row %0d with empty scoreboard", scan_row_o);
        end else begin
          chk("scan_row", scan_row_o, q[0].row);
          chk("scan_data", scan_data_o, q[0].data);
          chk("scan_last", scan_last_o, q[0].row == H-1);
          if (scan_ready_i) begin
            void'(q.pop_front());
            n_beats++;
            if (scan_last_o) n_last++;
          end
        end
      end else begin
        chk("scan_last_idle", scan_last_o, 1'b0);
      end
      if (prev_stall) begin
        chk("stall_row_stable", scan_row_o, prev_row);
        chk("stall_data_stable", scan_data_o, prev_data);
      end
      prev_stall = scan_v_o && !scan_ready_i;
      prev_row   = scan_row_o;
      prev_data  = scan_data_o;
    end
  end

  initial begin
    int busy_cnt, done_cnt, beats0, last0, c;
    reset_i = 1; mm_read_addr_i = 0; mm_write_addr_i = 0; mm_write_data_i = 0;
    idle_inputs();
    model_reset();

    // Reset state.
    #1;
    chk("rst_busy", busy_o, 0); chk("rst_done", clear_done_o, 0);
    chk("rst_scan_v", scan_v_o, 0); chk("rst_scan_row", scan_row_o, 0);
    chk("rst_scan_data", scan_data_o, 0); chk("rst_scan_last", scan_last_o, 0);
    chk("rst_top", top_occupied_o, 0);
    @(posedge clk); @(posedge clk); #1;
    reset_i = 0;
    rd_all("rst_rows");

    // Read-after-write: no same-cycle bypass.
    @(posedge clk); #1;
    mm_read_addr_i = 5'd31;
    mm_write_v_i = 1; mm_write_addr_i = 5'd31; mm_write_data_i = 16'hFFFF;
    #1;
    chk("raw_write_cycle", mm_read_data_o, 16'h0000);
    step();
    mm_write_v_i = 0;
    chk("raw_next_cycle", mm_read_data_o, 16'hFFFF);
    rd_all("raw_rows");

    // Clear sequence with writes attempted while busy.
    @(posedge clk); #1;
    for (int i = 0; i < H; i++) wr(i, 16'hA5A5);
    clear_i = 1; step(); clear_i = 0;
    busy_cnt = busy_o ? 1 : 0; done_cnt = clear_done_o ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      mm_write_v_i    = (clr_left > 0);
      mm_write_addr_i = 5'($urandom_range(0, H-1));
      mm_write_data_i = W'($urandom);
      clear_i         = (clr_left > 0) && ($urandom_range(0, 3) == 0);
      mm_read_addr_i  = 5'($urandom_range(0, H-1));
      step();
      if (busy_o) busy_cnt++;
      if (clear_done_o) done_cnt++;
    end
    idle_inputs();
    chk("clear_busy_cycles", busy_cnt, H);
    chk("clear_done_pulses", done_cnt, 1);
    rd_all("clear_rows");

    // Clear and write in the same idle cycle: the write is dropped.
    @(posedge clk); #1;
    wr(5, 16'h1234);
    clear_i = 1; mm_write_v_i = 1; mm_write_addr_i = 5'd5; mm_write_data_i = 16'h00FF;
    step();
    idle_inputs();
    c = 0;
    while (clr_left > 0 && c < 50) begin step(); c++; end
    chk("collision_clear_finished", busy_o, 0);
    mm_read_addr_i = 5'd5; #1;
    chk("collision_row5", mm_read_data_o, 16'h0000);

    // Scan with alternating back-pressure and writes to the stalled row.
    for (int i = 0; i < H; i++) wr(i, W'(i));
    beats0 = n_beats; last0 = n_last;
    scan_start_i = 1; scan_ready_i = 0; step(); scan_start_i = 0;
    c = 0;
    while (m_row >= 0 && c < 200) begin
      scan_ready_i = (c % 2 == 1);
      scan_start_i = (c % 7 == 3);
      if (!scan_ready_i) begin
        mm_write_v_i = 1; mm_write_addr_i = 5'(m_row); mm_write_data_i = W'($urandom) | 16'h8000;
      end else begin
        mm_write_v_i = 0;
      end
      step();
      c++;
    end
    idle_inputs();
    chk("scan_finished", m_row >= 0, 0);
    chk("scan_beats", n_beats - beats0, H);
    chk("scan_last_count", n_last - last0, 1);
    chk("scan_queue_empty", q.size(), 0);

    // Top-occupied flag.
    wr(0, 16'h0010);
    chk("top_set", top_occupied_o, 1);
    wr(0, 16'h0000);
    chk("top_clear", top_occupied_o, 0);

    // Randomized mix of writes, clears, scans and back-pressure.
    for (int i = 0; i < 500; i++) begin
      mm_write_v_i    = ($urandom_range(0, 1) == 1);
      mm_write_addr_i = 5'($urandom_range(0, H-1));
      mm_write_data_i = W'($urandom);
      clear_i         = ($urandom_range(0, 40) == 0);
      scan_start_i    = ($urandom_range(0, 15) == 0);
      scan_ready_i    = ($urandom_range(0, 2) != 0);
      mm_read_addr_i  = 5'($urandom_range(0, H-1));
      step();
    end
    idle_inputs();
    scan_ready_i = 1;
    c = 0;
    while ((clr_left > 0 || m_row >= 0) && c < 200) begin step(); c++; end
    scan_ready_i = 0;
    chk("random_drained", (clr_left > 0) || (m_row >= 0), 0);
    rd_all("random_rows");

    // Asynchronous reset in the middle of a clear and a scan.
    @(posedge clk); #1;
    wr(0, 16'h0001); wr(31, 16'h1234);
    clear_i = 1; scan_start_i = 1; scan_ready_i = 0; step();
    clear_i = 0; scan_start_i = 0;
    for (int i = 0; i < 5; i++) step();
    #2;
    reset_i = 1;
    #1;
    chk("areset_busy", busy_o, 0);
    chk("areset_scan_v", scan_v_o, 0);
    chk("areset_done", clear_done_o, 0);
    chk("areset_top", top_occupied_o, 0);
    chk("areset_scan_data", scan_data_o, 0);
    mm_read_addr_i = 5'd31; #1;
    chk("areset_row31", mm_read_data_o, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset_i = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (clear_done_o) done_cnt++;
    end
    chk("areset_no_done_pulse", done_cnt, 0);
    rd_all("areset_rows");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_mem.md
Name: matrix_mem

Overview:
- Playfield storage array for the game matrix: `height_p` rows of `width_p` bits, row 0 at top, row `height_p-1` at bottom.
- Acts as the responder for the executor matrix-memory interface: combinational same-cycle read data, plus a synchronous write port.
- Adds a sequenced whole-field clear for new games.
- Adds a flow-controlled row-scan stream for the display path.

Parameters:
- `width_p`, 16, bits per row (playfield width).
- `height_p`, 32, number of rows; address width is `$clog2(height_p)`.

Ports:
- `clk_i`  input  1  clock.
- `reset_i`  input  1  reset, asynchronous, active-high.
- `mm_read_addr_i`  input  `$clog2(height_p)`  executor read row address.
- `mm_read_data_o`  output  `width_p`  contents of the addressed row, same cycle.
- `mm_write_addr_i`  input  `$clog2(height_p)`  executor write row address.
- `mm_write_data_i`  input  `width_p`  executor write data.
- `mm_write_v_i`  input  1  executor write strobe.
- `clear_i`  input  1  request to zero the whole field.
- `busy_o`  output  1  clear sequence in progress.
- `clear_done_o`  output  1  one-cycle pulse when the clear completes.
- `scan_start_i`  input  1  start streaming rows 0..`height_p-1`.
- `scan_v_o`  output  1  scan row valid.
- `scan_ready_i`  input  1  scan consumer ready.
- `scan_row_o`  output  `$clog2(height_p)`  row index of `scan_data_o`.
- `scan_data_o`  output  `width_p`  row contents.
- `scan_last_o`  output  1  current scan beat is row `height_p-1`.
- `top_occupied_o`  output  1  OR-reduction of row 0 (game-over indication).

Behaviour:
- **Reset.** Asynchronous assertion of `reset_i` forces:
  - all array rows to 0;
  - clear FSM to eIDLE and scan FSM to sIDLE;
  - `busy_o`=0, `clear_done_o`=0, `scan_v_o`=0, `scan_row_o`=0, `scan_data_o`=0, `scan_last_o`=0, `top_occupied_o`=0.
  - Reset mid-clear or mid-scan aborts both with no pulse.
- **Read port.**
  - `mm_read_data_o` = `array[mm_read_addr_i]`, purely combinational.
  - A write becomes visible on the read port the cycle after the write edge.
  - No bypass of a same-cycle write.
- **Write port.**
  - When `mm_write_v_i`=1 in eIDLE, `array[mm_write_addr_i]` <= `mm_write_data_i` at the clock edge.
  - An address ≥ `height_p` (non-power-of-two heights) is ignored.
  - Writes are ignored while `busy_o`=1.
- **Clear FSM, states eIDLE and eCLEAR.**
  - eIDLE, `clear_i`=1: go to eCLEAR with clear pointer = 0.
  - eCLEAR: each cycle zero `array[ptr]` and increment `ptr`.
  - When `ptr`==`height_p-1`, zero that row, go to eIDLE, and assert `clear_done_o` for that one cycle.
  - `busy_o` = (state==eCLEAR).
  - Total occupancy is exactly `height_p` cycles.
  - `clear_i` during eCLEAR is ignored; it does not restart the sequence.
  - In eIDLE, `clear_i` and `mm_write_v_i` in the same cycle: the clear wins and the write is dropped.
- **Scan FSM, states sIDLE and sRUN.**
  - sIDLE, `scan_start_i`=1: at the next edge capture `array[0]` into `scan_data_o`, set `scan_row_o`=0, `scan_v_o`=1, and go to sRUN.
  - In sRUN, when `scan_v_o`&&`scan_ready_i`:
    - if `scan_row_o`==`height_p-1`: `scan_v_o` <= 0, go to sIDLE;
    - otherwise: `scan_row_o` <= `scan_row_o`+1 and capture `array[scan_row_o+1]`.
  - While `scan_v_o`&&!`scan_ready_i`, `scan_row_o` and `scan_data_o` hold stable, even if the array row is rewritten.
  - A capture in the same cycle as a write to that row captures the pre-write contents.
  - `scan_last_o` = `scan_v_o` && (`scan_row_o`==`height_p-1`).
  - `scan_start_i` in sRUN is ignored.
  - Scan runs independently of the clear FSM; rows captured during eCLEAR reflect the array at the capture edge.
- **Top-occupied flag.** `top_occupied_o` = |`array[0]`, combinational from storage.

Test Plan:
- **Reset and read-after-write.** Reset, then write `addr`=31 `data`=16'hFFFF -> `mm_read_data_o` reads 0 at addr 31 in the write cycle and 16'hFFFF the following cycle; all other rows read 0.
- **Clear sequence.** Fill all rows with 16'hA5A5, pulse `clear_i` -> `busy_o` high exactly 32 cycles, `clear_done_o` a single pulse in the 32nd, every row then reads 0. Writes issued during busy have no effect.
- **Clear/write collision.** `clear_i` and `mm_write_v_i` (addr 5, 16'h00FF) in the same eIDLE cycle -> row 5 reads 0 after `clear_done_o`.
- **Scan with back-pressure.** Rows hold row index as data, `scan_ready_i` toggles 1/0 -> 32 accepted beats, `scan_row_o`=`scan_data_o`=0..31 in order, `scan_last_o` only on beat 31, data stable across stalled cycles. A write to the stalled row does not change `scan_data_o`.
- **Top-occupied flag.** Write row 0 = 16'h0010 -> `top_occupied_o`=1 next cycle; write row 0 = 0 -> returns to 0.
- **Asynchronous reset mid-operation.** Assert `reset_i` asynchronously between edges mid-clear and mid-scan -> `busy_o`, `scan_v_o` drop immediately, array reads 0, no `clear_done_o` pulse.
